unidade_controle: RTL
=====================

# unidade_controle

- Multicycle control FSM for the CPU datapath; the other end of the control-signal interface.
- Consumes the decoded instruction fields (`OpCode`, `Func`) and the ALU `EQ` flag.
- Drives every register write-enable, mux select, ALU operation and memory strobe of the datapath.
- Supports `add`, `sub`, `and`, `slt`, `addi`, `lw`, `sw`, `beq`, `bne`, `j`, with wait states for the one-cycle-latency memory.

## Interface
No parameters.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `reset` in 1 — asynchronous, active-low.
- `OpCode` in 6 — instruction bits [31:26] from the IR.
- `Func` in 6 — instruction bits [5:0].
- `EQ` in 1 — ALU equality flag.
- `PCLoad` out 1 — PC write enable.
- `SrcAddressMem` out 3 — memory address select: 0 = PC, 1 = ALUOut.
- `MemOp` out 1 — 0 = read, 1 = write.
- `IRWrite` out 1 — instruction register load.
- `RegWrite` out 1 — register file write.
- `WriteA` out 1, `WriteB` out 1 — A and B register loads.
- `ALUSrcA` out 2 — ALU A operand: 0 = PC, 1 = A.
- `ALUSrcB` out 3 — ALU B operand: 0 = B, 1 = const 4, 2 = sext(imm), 3 = sext(imm)<<2.
- `ALUOp` out 3 — 001 add, 010 sub, 011 and, 111 compare.
- `WriteALUOut` out 1 — ALUOut load.
- `PCSource` out 2 — 0 = ALUResult, 1 = ALUOut, 2 = jump target.
- `MemToReg` out 3 — 0 = ALUOut, 1 = MemOut, 6 = LT32.
- `RegDst` out 3 — 0 = rt, 1 = rd.
- `OpInvalid` out 1 — one-cycle pulse on an unsupported opcode or funct.
- `State` out 6 — current state code, for debug and verification.

## Operation
- Outputs are a pure decode of the state register. The one exception is `PCLoad` in BRANCH, which also depends on `EQ`.
- Any output not listed for a state is 0.
- State codes and asserted outputs:
  - RESET=0: all outputs 0.
  - F0=1: `SrcAddressMem`=0, `MemOp`=0 (issues the read).
  - F1=2: `ALUSrcA`=0, `ALUSrcB`=1, `ALUOp`=add, `PCSource`=0, `PCLoad`=1.
  - F2=3: `SrcAddressMem`=0, `IRWrite`=1.
  - DECODE=4: `WriteA`, `WriteB`; `ALUSrcA`=0, `ALUSrcB`=3, `ALUOp`=add, `WriteALUOut` (precomputes the branch target).
  - EXEC_R=5: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp` from `Func` (0x20 add, 0x22 sub, 0x24 and), `WriteALUOut`.
  - WB_R=6: `RegDst`=1, `MemToReg`=0, `RegWrite`.
  - WB_SLT=7: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=111, `RegDst`=1, `MemToReg`=6, `RegWrite`.
  - EXEC_I=8 and ADDR=10: `ALUSrcA`=1, `ALUSrcB`=2, `ALUOp`=add, `WriteALUOut`.
  - WB_I=9: `RegDst`=0, `MemToReg`=0, `RegWrite`.
  - RD0=11, RD1=12: `SrcAddressMem`=1, `MemOp`=0.
  - WB_LW=13: `SrcAddressMem`=1, `RegDst`=0, `MemToReg`=1, `RegWrite`.
  - WR=14: `SrcAddressMem`=1, `MemOp`=1.
  - BRANCH=15: `ALUSrcA`=1, `ALUSrcB`=0, `ALUOp`=111, `PCSource`=1.
    - `PCLoad` = (`OpCode`==0x04 & `EQ`) | (`OpCode`==0x05 & !`EQ`).
  - JUMP=16: `PCSource`=2, `PCLoad`=1.
  - INVALID=17: `OpInvalid`=1.
- Transitions:
  - RESET→F0, F0→F1→F2→DECODE.
  - DECODE dispatches on `OpCode`:
    - 0x00 with `Func` 0x20/0x22/0x24 → EXEC_R; with `Func` 0x2A → WB_SLT; any other `Func` → INVALID.
    - 0x08 → EXEC_I.
    - 0x23 or 0x2B → ADDR.
    - 0x04 or 0x05 → BRANCH.
    - 0x02 → JUMP.
    - anything else → INVALID.
  - EXEC_R→WB_R, EXEC_I→WB_I.
  - ADDR→RD0 if `OpCode`==0x23, else → WR.
  - RD0→RD1→WB_LW.
  - WB_R, WB_SLT, WB_I, WB_LW, WR, BRANCH, JUMP, INVALID → F0.
- `OpCode` and `Func` are sampled only in DECODE, EXEC_R, ADDR and BRANCH; IR is stable there. Unreachable state codes → F0 on the next edge.

## Timing
- `reset` low: state forced to RESET immediately, regardless of clock; all outputs 0 combinationally, including mid-instruction. No write strobe may be asserted while `reset` is low.
- First rising edge with `reset` high: RESET→F0. The next instruction fetch starts from the current PC (datapath reset clears PC).
- Cycle counts from F0 to the next F0:
  - R-type add/sub/and, addi, sw: 6.
  - slt, beq/bne, j, invalid: 5.
  - lw: 8.
- Memory read data is valid two edges after the address is presented (F0→F2, RD0→WB_LW). The address select is held through those states.
- PC is incremented exactly once per instruction, in F1. DECODE uses the incremented PC.

## Test plan
- Reset in WB_R (`State`=6): drop `reset` between edges → `State`=0 and `RegWrite`=0 with no clock edge. Release → F0 on the next edge.
- `OpCode`=0x00, `Func`=0x22: state sequence 1,2,3,4,5,6,1. `ALUOp`=010 in state 5. `RegWrite`=1, `RegDst`=1 only in state 6.
- `OpCode`=0x23: sequence 1,2,3,4,10,11,12,13,1. `SrcAddressMem`=1 in states 11–13. `MemToReg`=1 with `RegWrite` in state 13.
- `OpCode`=0x04 in BRANCH: `EQ`=1 → `PCLoad`=1; `EQ`=0 → `PCLoad`=0. Repeat with 0x05 and expect the inverse.
- `OpCode`=0x3F, then `OpCode`=0x00 with `Func`=0x07: each goes 4→17. `OpInvalid` high exactly one cycle; no `RegWrite`/`MemOp`/`PCLoad`; returns to F0.
- `OpCode`=0x02: state 16 with `PCSource`=2, `PCLoad`=1. Across any instruction, `PCLoad` asserts in F1 exactly once per fetch.

Source files
------------

// File: rtl/unidade_controle_if.sv
// unidade_controle_if
//   Control-signal bundle between the multicycle control unit and the CPU
//   datapath.
//   master (control unit): takes OpCode, Func, EQ; drives every strobe, select
//                          and the State debug code.
//   slave  (datapath):     drives OpCode, Func, EQ; takes the control signals.
interface unidade_controle_if;
  logic [5:0] OpCode;
  logic [5:0] Func;
  logic       EQ;

  logic       PCLoad;
  logic [2:0] SrcAddressMem;
  logic       MemOp;
  logic       IRWrite;
  logic       RegWrite;
  logic       WriteA;
  logic       WriteB;
  logic [1:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       WriteALUOut;
  logic [1:0] PCSource;
  logic [2:0] MemToReg;
  logic [2:0] RegDst;
  logic       OpInvalid;
  logic [5:0] State;

  modport master (
    input  OpCode, Func, EQ,
    output PCLoad, SrcAddressMem, MemOp, IRWrite, RegWrite, WriteA, WriteB,
           ALUSrcA, ALUSrcB, ALUOp, WriteALUOut, PCSource, MemToReg, RegDst,
           OpInvalid, State
  );

  modport slave (
    output OpCode, Func, EQ,
    input  PCLoad, SrcAddressMem, MemOp, IRWrite, RegWrite, WriteA, WriteB,
           ALUSrcA, ALUSrcB, ALUOp, WriteALUOut, PCSource, MemToReg, RegDst,
           OpInvalid, State
  );
endinterface

// File: rtl/unidade_controle.sv
// unidade_controle
//   Multicycle control FSM for the CPU datapath. Handles add, sub, and, slt,
//   addi, lw, sw, beq, bne and j, with wait states for the one-cycle-latency
//   memory.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low; forces RESET (all outputs 0) at once
//   ctl   - control bundle (master side): OpCode/Func/EQ in, controls out
//
// state   | code | meaning
// RESET   |  0   | held in / leaving reset, all outputs 0
// F0      |  1   | present PC to memory (read)
// F1      |  2   | PC <= PC + 4
// F2      |  3   | read data valid, load IR
// DECODE  |  4   | load A/B, precompute branch target into ALUOut
// EXEC_R  |  5   | R-type add/sub/and into ALUOut
// WB_R    |  6   | write ALUOut to rd
// WB_SLT  |  7   | compare A,B and write LT32 to rd
// EXEC_I  |  8   | addi: A + sext(imm) into ALUOut
// WB_I    |  9   | write ALUOut to rt
// ADDR    | 10   | lw/sw effective address into ALUOut
// RD0     | 11   | present ALUOut address (read)
// RD1     | 12   | memory wait
// WB_LW   | 13   | write MemOut to rt
// WR      | 14   | memory write at ALUOut
// BRANCH  | 15   | compare, load PC from ALUOut if taken
// JUMP    | 16   | load PC with jump target
// INVALID | 17   | one-cycle OpInvalid pulse
module unidade_controle (
  input  logic               clk,
  input  logic               reset,
  unidade_controle_if.master ctl
);

  typedef enum logic [5:0] {
    S_RESET   = 6'd0,
    S_F0      = 6'd1,
    S_F1      = 6'd2,
    S_F2      = 6'd3,
    S_DECODE  = 6'd4,
    S_EXEC_R  = 6'd5,
    S_WB_R    = 6'd6,
    S_WB_SLT  = 6'd7,
    S_EXEC_I  = 6'd8,
    S_WB_I    = 6'd9,
    S_ADDR    = 6'd10,
    S_RD0     = 6'd11,
    S_RD1     = 6'd12,
    S_WB_LW   = 6'd13,
    S_WR      = 6'd14,
    S_BRANCH  = 6'd15,
    S_JUMP    = 6'd16,
    S_INVALID = 6'd17
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_CMP = 3'b111;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_F0;
    case (state_q)
      S_RESET:  state_d = S_F0;
      S_F0:     state_d = S_F1;
      S_F1:     state_d = S_F2;
      S_F2:     state_d = S_DECODE;
      S_DECODE: begin
        case (ctl.OpCode)
          OP_RTYPE: begin
            case (ctl.Func)
              FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
              FN_SLT:                 state_d = S_WB_SLT;
              default:                state_d = S_INVALID;
            endcase
          end
          OP_ADDI:        state_d = S_EXEC_I;
          OP_LW, OP_SW:   state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_INVALID;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_ADDR:   state_d = (ctl.OpCode == OP_LW) ? S_RD0 : S_WR;
      S_RD0:    state_d = S_RD1;
      S_RD1:    state_d = S_WB_LW;
      // All terminal states, plus any unreachable code, restart the fetch.
      default:  state_d = S_F0;
    endcase
  end

  logic       pc_load;
  logic [2:0] src_address_mem;
  logic       mem_op;
  logic       ir_write;
  logic       reg_write;
  logic       write_a;
  logic       write_b;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [2:0] alu_op;
  logic       write_alu_out;
  logic [1:0] pc_source;
  logic [2:0] mem_to_reg;
  logic [2:0] reg_dst;
  logic       op_invalid;

  always_comb begin
    pc_load         = 1'b0;
    src_address_mem = 3'd0;
    mem_op          = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    write_a         = 1'b0;
    write_b         = 1'b0;
    alu_src_a       = 2'd0;
    alu_src_b       = 3'd0;
    alu_op          = 3'd0;
    write_alu_out   = 1'b0;
    pc_source       = 2'd0;
    mem_to_reg      = 3'd0;
    reg_dst         = 3'd0;
    op_invalid      = 1'b0;
    case (state_q)
      S_F1: begin
        alu_src_b = 3'd1;
        alu_op    = ALU_ADD;
        pc_load   = 1'b1;
      end
      S_F2: ir_write = 1'b1;
      S_DECODE: begin
        write_a       = 1'b1;
        write_b       = 1'b1;
        alu_src_b     = 3'd3;
        alu_op        = ALU_ADD;
        write_alu_out = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a     = 2'd1;
        write_alu_out = 1'b1;
        case (ctl.Func)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          default: alu_op = 3'd0;
        endcase
      end
      S_WB_R: begin
        reg_dst   = 3'd1;
        reg_write = 1'b1;
      end
      S_WB_SLT: begin
        alu_src_a  = 2'd1;
        alu_op     = ALU_CMP;
        reg_dst    = 3'd1;
        mem_to_reg = 3'd6;
        reg_write  = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a     = 2'd1;
        alu_src_b     = 3'd2;
        alu_op        = ALU_ADD;
        write_alu_out = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_RD0, S_RD1: src_address_mem = 3'd1;
      S_WB_LW: begin
        src_address_mem = 3'd1;
        mem_to_reg      = 3'd1;
        reg_write       = 1'b1;
      end
      S_WR: begin
        src_address_mem = 3'd1;
        mem_op          = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'd1;
        alu_op    = ALU_CMP;
        pc_source = 2'd1;
        // beq takes on equal, bne on not-equal.
        pc_load   = ((ctl.OpCode == OP_BEQ) &&  ctl.EQ) ||
                    ((ctl.OpCode == OP_BNE) && !ctl.EQ);
      end
      S_JUMP: begin
        pc_source = 2'd2;
        pc_load   = 1'b1;
      end
      S_INVALID: op_invalid = 1'b1;
      default: ;
    endcase
  end

  assign ctl.PCLoad        = pc_load;
  assign ctl.SrcAddressMem = src_address_mem;
  assign ctl.MemOp         = mem_op;
  assign ctl.IRWrite       = ir_write;
  assign ctl.RegWrite      = reg_write;
  assign ctl.WriteA        = write_a;
  assign ctl.WriteB        = write_b;
  assign ctl.ALUSrcA       = alu_src_a;
  assign ctl.ALUSrcB       = alu_src_b;
  assign ctl.ALUOp         = alu_op;
  assign ctl.WriteALUOut   = write_alu_out;
  assign ctl.PCSource      = pc_source;
  assign ctl.MemToReg      = mem_to_reg;
  assign ctl.RegDst        = reg_dst;
  assign ctl.OpInvalid     = op_invalid;
  assign ctl.State         = state_q;

endmodule
